mips_mc_control: RTL and testbench
==================================

Name: mips_mc_control

Overview:
- Multi-cycle MIPS main control FSM, directly upstream of the ALU control stage.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives all datapath enables and the 3-bit ALUOp consumed by the ALU control block.
- ALUOp encoding: 0 = R-type (ALU control decodes Func); any other value is passed through as the ALU select.

Parameters:
- OPW, 6, opcode width
- ALUOPW, 3, ALUOp width (must match the ALU control input)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPW  IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero (branch)
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  register write data from MDR
- RegDst  out  1  1 = rd, 0 = rt
- RegWrite  out  1  register file write
- ZeroExt  out  1  zero-extend immediate (ori)
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = imm, 11 = imm<<2
- PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
- ALUOp  out  ALUOPW  to ALU control
- instr_done  out  1  one-cycle pulse in the final cycle of each instruction
- illegal  out  1  one-cycle pulse on an unknown opcode
- state  out  4  current state (debug)

Behaviour:
- Moore outputs are decoded from the state register. Exceptions: PCWrite/IRWrite in FETCH and instr_done in MEMWR are additionally gated by mem_ready.
- Default for any output not listed in a state: 0, except ALUOp = ADD(2) in every state other than IDLE.
- Reset: rst_n low forces state to IDLE asynchronously. All outputs are 0 in IDLE, including ALUOp = 0. This applies even mid-instruction; memory strobes drop immediately.
- IDLE -> FETCH unconditionally after reset release.
- FETCH: MemRead, IorD=0, SrcA=0, SrcB=01, ALUOp=ADD. Holds while mem_ready=0. When mem_ready=1: IRWrite=1, PCWrite=1, next DECODE. PC increments exactly once per fetch.
- DECODE: SrcA=0, SrcB=11, ALUOp=ADD (branch target). Next state by opcode:
  - 0 -> EXEC
  - 35/43 -> MEMADR
  - 4 -> BRANCH
  - 2 -> JUMP
  - 8 -> ADDIEX
  - 13 -> ORIEX
  - 10 -> SLTIEX
  - other -> FETCH, with illegal=1 this cycle; the instruction is a NOP.
- MEMADR: SrcA=1, SrcB=10, ADD. Next MEMRD (35) or MEMWR (43).
- MEMRD: IorD=1, MemRead. Holds while mem_ready=0, then MEMWB.
- MEMWB: RegDst=0, MemtoReg=1, RegWrite, instr_done. Next FETCH.
- MEMWR: IorD=1, MemWrite. Holds while mem_ready=0. On mem_ready: instr_done, next FETCH.
- EXEC: SrcA=1, SrcB=00, ALUOp=0. Next ALUWB.
- ALUWB: RegDst=1, RegWrite, instr_done. Next FETCH.
- BRANCH: SrcA=1, SrcB=00, ALUOp=SUB(6), PCWriteCond, PCSource=01, instr_done. Next FETCH.
- JUMP: PCWrite, PCSource=10, instr_done. Next FETCH.
- ADDIEX: SrcA=1, SrcB=10, ALUOp=ADD(2).
- ORIEX: same as ADDIEX but ALUOp=OR(1), ZeroExt=1.
- SLTIEX: same as ADDIEX but ALUOp=SLT(7).
- ADDIEX/ORIEX/SLTIEX all go to IWB.
- IWB: RegDst=0, MemtoReg=0, RegWrite, instr_done. Next FETCH.
- Latency with zero wait states (FETCH through done): R/sw/addi/ori/slti = 4 cycles, lw = 5, beq/j = 3. Each mem_ready=0 cycle adds 1.
- Unused state encodings fall to IDLE on the next clock.
- opcode is sampled only in DECODE and MEMADR.

Decomposition:
- Package mips_pkg holds:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI, OP_SLTI)
  - ALUOp constants (ALUOP_RTYPE=0, ALUOP_OR=1, ALUOP_ADD=2, ALUOP_SUB=6, ALUOP_SLT=7), shared with ALU control
  - the 4-bit state enum
- Sub-module mips_ctrl_decode: combinational state + mem_ready -> output decoder. The top level keeps the state register and next-state logic.

Test Plan:
- Reset: hold rst_n=0 -> all outputs 0, state=IDLE. Release -> FETCH one cycle later, MemRead=1, ALUOp=2.
- R-type (opcode 0), mem_ready=1 -> FETCH, DECODE, EXEC (ALUOp=0, SrcA=1), ALUWB (RegWrite=1, RegDst=1, instr_done=1). Exactly 4 cycles, PCWrite pulses once.
- lw (35) with mem_ready low for 2 MEMRD cycles -> 7 cycles total, MemRead+IorD=1 for 3 cycles, MEMWB MemtoReg=1, RegWrite=1.
- beq (4) -> BRANCH with ALUOp=6, PCWriteCond=1, PCSource=01, instr_done=1. Back in FETCH on cycle 4.
- ori (13) -> ORIEX with ALUOp=1, ZeroExt=1, then IWB with RegWrite=1, RegDst=0.
- Illegal opcode 6'h3F -> illegal=1 in DECODE, FETCH next cycle, no RegWrite/MemWrite. Then assert rst_n=0 mid-MEMWR -> MemWrite drops combinationally, state=IDLE.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared opcode, ALUOp and control-state definitions for the
//                multi-cycle MIPS control path.
//  Revision    : 1.0
// ============================================================================
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'd0;
    localparam logic [5:0] OP_J     = 6'd2;
    localparam logic [5:0] OP_BEQ   = 6'd4;
    localparam logic [5:0] OP_ADDI  = 6'd8;
    localparam logic [5:0] OP_SLTI  = 6'd10;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_LW    = 6'd35;
    localparam logic [5:0] OP_SW    = 6'd43;

    localparam logic [2:0] ALUOP_RTYPE = 3'd0;
    localparam logic [2:0] ALUOP_OR    = 3'd1;
    localparam logic [2:0] ALUOP_ADD   = 3'd2;
    localparam logic [2:0] ALUOP_SUB   = 3'd6;
    localparam logic [2:0] ALUOP_SLT   = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_JUMP   = 4'd10,
        ST_ADDIEX = 4'd11,
        ST_ORIEX  = 4'd12,
        ST_SLTIEX = 4'd13,
        ST_IWB    = 4'd14
    } state_t;

    function automatic logic op_legal(input logic [5:0] op);
        return op inside {OP_RTYPE, OP_J, OP_BEQ, OP_ADDI,
                          OP_SLTI, OP_ORI, OP_LW, OP_SW};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_ctrl_decode.sv
`default_nettype none
// ============================================================================
//  Module      : mips_ctrl_decode
//  Description : Combinational Moore decoder from control state to datapath
//                enables; FETCH and MEMWR handshakes are gated by mem_ready.
//  Revision    : 1.0
// ============================================================================
module mips_ctrl_decode
    import mips_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  state_t              i_state,
    input  logic                i_mem_ready,
    input  logic [OPW-1:0]      i_opcode,
    output logic                o_pc_write,
    output logic                o_pc_write_cond,
    output logic                o_iord,
    output logic                o_mem_read,
    output logic                o_mem_write,
    output logic                o_ir_write,
    output logic                o_mem_to_reg,
    output logic                o_reg_dst,
    output logic                o_reg_write,
    output logic                o_zero_ext,
    output logic                o_alu_src_a,
    output logic [1:0]          o_alu_src_b,
    output logic [1:0]          o_pc_source,
    output logic [ALUOPW-1:0]   o_alu_op,
    output logic                o_instr_done,
    output logic                o_illegal
);

    logic [5:0] w_op;
    assign w_op = 6'(i_opcode);

    always_comb begin
        o_pc_write      = 1'b0;
        o_pc_write_cond = 1'b0;
        o_iord          = 1'b0;
        o_mem_read      = 1'b0;
        o_mem_write     = 1'b0;
        o_ir_write      = 1'b0;
        o_mem_to_reg    = 1'b0;
        o_reg_dst       = 1'b0;
        o_reg_write     = 1'b0;
        o_zero_ext      = 1'b0;
        o_alu_src_a     = 1'b0;
        o_alu_src_b     = 2'b00;
        o_pc_source     = 2'b00;
        o_alu_op        = (i_state == ST_IDLE) ? '0 : ALUOPW'(ALUOP_ADD);
        o_instr_done    = 1'b0;
        o_illegal       = 1'b0;
        case (i_state)
            ST_FETCH: begin
                o_mem_read  = 1'b1;
                o_alu_src_b = 2'b01;
                o_ir_write  = i_mem_ready;
                o_pc_write  = i_mem_ready;
            end
            ST_DECODE: begin
                o_alu_src_b = 2'b11;
                o_illegal   = !op_legal(w_op);
            end
            ST_MEMADR: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
            end
            ST_MEMRD: begin
                o_iord     = 1'b1;
                o_mem_read = 1'b1;
            end
            ST_MEMWB: begin
                o_mem_to_reg = 1'b1;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            ST_MEMWR: begin
                o_iord       = 1'b1;
                o_mem_write  = 1'b1;
                o_instr_done = i_mem_ready;
            end
            ST_EXEC: begin
                o_alu_src_a = 1'b1;
                o_alu_op    = ALUOPW'(ALUOP_RTYPE);
            end
            ST_ALUWB: begin
                o_reg_dst    = 1'b1;
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            ST_BRANCH: begin
                o_alu_src_a     = 1'b1;
                o_alu_op        = ALUOPW'(ALUOP_SUB);
                o_pc_write_cond = 1'b1;
                o_pc_source     = 2'b01;
                o_instr_done    = 1'b1;
            end
            ST_JUMP: begin
                o_pc_write   = 1'b1;
                o_pc_source  = 2'b10;
                o_instr_done = 1'b1;
            end
            ST_ADDIEX, ST_ORIEX, ST_SLTIEX: begin
                o_alu_src_a = 1'b1;
                o_alu_src_b = 2'b10;
                if (i_state == ST_ORIEX) begin
                    o_alu_op   = ALUOPW'(ALUOP_OR);
                    o_zero_ext = 1'b1;
                end else if (i_state == ST_SLTIEX) begin
                    o_alu_op = ALUOPW'(ALUOP_SLT);
                end
            end
            ST_IWB: begin
                o_reg_write  = 1'b1;
                o_instr_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : mips_mc_control
//  Description : Multi-cycle MIPS main control FSM: state register, next-state
//                logic and the Moore output decoder feeding the datapath.
//  Revision    : 1.0
// ============================================================================
module mips_mc_control
    import mips_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [OPW-1:0]      opcode,
    input  logic                mem_ready,
    output logic                PCWrite,
    output logic                PCWriteCond,
    output logic                IorD,
    output logic                MemRead,
    output logic                MemWrite,
    output logic                IRWrite,
    output logic                MemtoReg,
    output logic                RegDst,
    output logic                RegWrite,
    output logic                ZeroExt,
    output logic                ALUSrcA,
    output logic [1:0]          ALUSrcB,
    output logic [1:0]          PCSource,
    output logic [ALUOPW-1:0]   ALUOp,
    output logic                instr_done,
    output logic                illegal,
    output logic [3:0]          state
);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] w_op;

    assign w_op  = 6'(opcode);
    assign state = r_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_next = ST_FETCH;
            ST_FETCH:  w_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (w_op)
                    OP_RTYPE:     w_next = ST_EXEC;
                    OP_LW, OP_SW: w_next = ST_MEMADR;
                    OP_BEQ:       w_next = ST_BRANCH;
                    OP_J:         w_next = ST_JUMP;
                    OP_ADDI:      w_next = ST_ADDIEX;
                    OP_ORI:       w_next = ST_ORIEX;
                    OP_SLTI:      w_next = ST_SLTIEX;
                    default:      w_next = ST_FETCH;
                endcase
            end
            ST_MEMADR: w_next = (w_op == OP_SW) ? ST_MEMWR : ST_MEMRD;
            ST_MEMRD:  w_next = mem_ready ? ST_MEMWB : ST_MEMRD;
            ST_MEMWR:  w_next = mem_ready ? ST_FETCH : ST_MEMWR;
            ST_EXEC:   w_next = ST_ALUWB;
            ST_ADDIEX, ST_ORIEX, ST_SLTIEX: w_next = ST_IWB;
            ST_MEMWB, ST_ALUWB, ST_BRANCH, ST_JUMP, ST_IWB: w_next = ST_FETCH;
            default:   w_next = ST_IDLE;
        endcase
    end

    mips_ctrl_decode #(
        .OPW    (OPW),
        .ALUOPW (ALUOPW)
    ) u_decode (
        .i_state         (r_state),
        .i_mem_ready     (mem_ready),
        .i_opcode        (opcode),
        .o_pc_write      (PCWrite),
        .o_pc_write_cond (PCWriteCond),
        .o_iord          (IorD),
        .o_mem_read      (MemRead),
        .o_mem_write     (MemWrite),
        .o_ir_write      (IRWrite),
        .o_mem_to_reg    (MemtoReg),
        .o_reg_dst       (RegDst),
        .o_reg_write     (RegWrite),
        .o_zero_ext      (ZeroExt),
        .o_alu_src_a     (ALUSrcA),
        .o_alu_src_b     (ALUSrcB),
        .o_pc_source     (PCSource),
        .o_alu_op        (ALUOp),
        .o_instr_done    (instr_done),
        .o_illegal       (illegal)
    );

endmodule
`default_nettype wire

// File: tb/tb_mips_mc_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips_mc_control
//  Description : Scoreboard bench for the multi-cycle MIPS control FSM.
//  Revision    : 1.0
// ============================================================================
module tb_mips_mc_control;
    import mips_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = '0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ZeroExt, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic       instr_done, illegal;
    logic [3:0] state;

    int errors = 0;
    int checks = 0;
    logic [23:0] exp_q[$];
    state_t      step_q[$];
    int          lat_q[$];
    int          cyc = 0;

    always #5 clk = ~clk;

    mips_mc_control #(.OPW(6), .ALUOPW(3)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ZeroExt(ZeroExt), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .ALUOp(ALUOp), .instr_done(instr_done),
        .illegal(illegal), .state(state)
    );

    function automatic logic [23:0] actual();
        return {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
                MemtoReg, RegDst, RegWrite, ZeroExt, ALUSrcA, ALUSrcB,
                PCSource, ALUOp, instr_done, illegal, state};
    endfunction

    function automatic bit known_op(input logic [5:0] op);
        return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 ||
               op == 6'd2 || op == 6'd8 || op == 6'd13 || op == 6'd10;
    endfunction

    // Reference: what each control step must drive, straight from the step descriptions.
    function automatic logic [23:0] expect_ctrl(input state_t s, input bit mr, input logic [5:0] op);
        logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, zx, sa, done, ill;
        logic [1:0] sb, ps;
        logic [2:0] aop;
        {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, zx, sa, done, ill} = '0;
        sb = 2'b00; ps = 2'b00;
        aop = (s == ST_IDLE) ? 3'd0 : 3'd2;
        case (s)
            ST_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
            ST_DECODE: begin sb = 2'b11; ill = !known_op(op); end
            ST_MEMADR: begin sa = 1; sb = 2'b10; end
            ST_MEMRD:  begin iord = 1; mrd = 1; end
            ST_MEMWB:  begin m2r = 1; rw = 1; done = 1; end
            ST_MEMWR:  begin iord = 1; mwr = 1; done = mr; end
            ST_EXEC:   begin sa = 1; aop = 3'd0; end
            ST_ALUWB:  begin rdst = 1; rw = 1; done = 1; end
            ST_BRANCH: begin sa = 1; aop = 3'd6; pcwc = 1; ps = 2'b01; done = 1; end
            ST_JUMP:   begin pcw = 1; ps = 2'b10; done = 1; end
            ST_ADDIEX: begin sa = 1; sb = 2'b10; end
            ST_ORIEX:  begin sa = 1; sb = 2'b10; aop = 3'd1; zx = 1; end
            ST_SLTIEX: begin sa = 1; sb = 2'b10; aop = 3'd7; end
            ST_IWB:    begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, zx, sa, sb,
                ps, aop, done, ill, 4'(s)};
    endfunction

    task automatic do_cycle(input state_t s, input bit mr, input logic [5:0] op);
        mem_ready = mr;
        opcode    = op;
        exp_q.push_back(expect_ctrl(s, mr, op));
        step_q.push_back(s);
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int base;
        int m;
        m = (op == 6'd35 || op == 6'd43) ? mw : 0;
        case (op)
            6'd35:       base = 5;
            6'd4, 6'd2:  base = 3;
            default:     base = 4;
        endcase
        if (known_op(op)) lat_q.push_back(base + fw + m);
        for (int i = 0; i < fw; i++) do_cycle(ST_FETCH, 1'b0, 6'($urandom));
        do_cycle(ST_FETCH, 1'b1, 6'($urandom));
        do_cycle(ST_DECODE, 1'($urandom), op);
        case (op)
            6'd0:  begin do_cycle(ST_EXEC, 1'($urandom), op); do_cycle(ST_ALUWB, 1'($urandom), op); end
            6'd35: begin
                do_cycle(ST_MEMADR, 1'($urandom), op);
                for (int i = 0; i < m; i++) do_cycle(ST_MEMRD, 1'b0, op);
                do_cycle(ST_MEMRD, 1'b1, op);
                do_cycle(ST_MEMWB, 1'($urandom), op);
            end
            6'd43: begin
                do_cycle(ST_MEMADR, 1'($urandom), op);
                for (int i = 0; i < m; i++) do_cycle(ST_MEMWR, 1'b0, op);
                do_cycle(ST_MEMWR, 1'b1, op);
            end
            6'd4:  do_cycle(ST_BRANCH, 1'($urandom), op);
            6'd2:  do_cycle(ST_JUMP, 1'($urandom), op);
            6'd8:  begin do_cycle(ST_ADDIEX, 1'($urandom), op); do_cycle(ST_IWB, 1'($urandom), op); end
            6'd13: begin do_cycle(ST_ORIEX, 1'($urandom), op); do_cycle(ST_IWB, 1'($urandom), op); end
            6'd10: begin do_cycle(ST_SLTIEX, 1'($urandom), op); do_cycle(ST_IWB, 1'($urandom), op); end
            default: ;
        endcase
    endtask

    // Monitor: per-cycle output compare plus FETCH-to-done latency.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                logic [23:0] e;
                state_t      s;
                e = exp_q.pop_front();
                s = step_q.pop_front();
                checks++;
                if (actual() !== e) begin
                    errors++;
                    $display("FAIL ctrl[%s] actual=%h required=%h @%0t", s.name(), actual(), e, $time);
                end
            end
            if (rst_n && state != 4'd0) cyc++;
            if (instr_done === 1'b1) begin
                checks++;
                if (lat_q.size() == 0) begin
                    errors++;
                    $display("FAIL latency actual=done_pulse required=no_instruction_pending @%0t", $time);
                end else begin
                    int l;
                    l = lat_q.pop_front();
                    if (cyc != l) begin
                        errors++;
                        $display("FAIL latency actual=%0d required=%0d @%0t", cyc, l, $time);
                    end
                end
                cyc = 0;
            end
            if (illegal === 1'b1) cyc = 0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [5:0] ops[8];
        logic [5:0] op;
        ops = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8, 6'd13, 6'd10};

        repeat (3) @(negedge clk);
        checks++;
        if (actual() !== 24'h0) begin
            errors++;
            $display("FAIL reset_outputs actual=%h required=%h", actual(), 24'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_cycle(ST_IDLE, 1'($urandom), 6'($urandom));

        run_instr(6'd0, 0, 0);
        run_instr(6'd35, 0, 2);
        run_instr(6'd4, 0, 0);
        run_instr(6'd13, 0, 0);
        run_instr(6'h3F, 0, 0);
        run_instr(6'd43, 1, 1);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom); while (known_op(op));
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            run_instr(op, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                      int'($urandom_range(0, 3)));
        end

        // Reset asserted while a store is waiting on memory.
        lat_q.push_back(-1);
        do_cycle(ST_FETCH, 1'b1, 6'd43);
        do_cycle(ST_DECODE, 1'b0, 6'd43);
        do_cycle(ST_MEMADR, 1'b0, 6'd43);
        mem_ready = 1'b0;
        exp_q.push_back(expect_ctrl(ST_MEMWR, 1'b0, 6'd43));
        step_q.push_back(ST_MEMWR);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (actual() !== 24'h0) begin
            errors++;
            $display("FAIL async_reset_memwr actual=%h required=%h", actual(), 24'h0);
        end
        repeat (2) @(negedge clk);
        lat_q.delete();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
